// File: rtl/key_code_pkg.sv
// key_code_pkg: shared types, default parameters and the key code table
// function for the front-panel key encoder.
package key_code_pkg;

  localparam int DEF_NUM_KEYS        = 4;
  localparam int DEF_CODE_W          = 8;
  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  // Widest code the table function can build
  localparam int MAX_CODE_W = 32;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ev_state_t;

  // Key idx sets bits code_w-1-2k for k = 0..idx; every other bit stays 0
  function automatic logic [MAX_CODE_W-1:0] key_code(input int idx, input int code_w);
    logic [MAX_CODE_W-1:0] c;
    c = '0;
    for (int k = 0; k < MAX_CODE_W / 2; k++) begin
      if ((k <= idx) && (code_w - 1 - 2 * k >= 0)) begin
        c = c | (MAX_CODE_W'(1) << (code_w - 1 - 2 * k));
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/key_code_encoder_if.sv
// key_code_encoder_if: press-event handshake between the key encoder
// (master) and the TX framing logic (slave).
interface key_code_encoder_if
  import key_code_pkg::*;
#(
  parameter int CODE_W = DEF_CODE_W
);
  logic [CODE_W-1:0] ev_code;
  logic              ev_valid;
  logic              ev_ready;
  logic              ev_drop;

  modport master (output ev_code, output ev_valid, output ev_drop, input ev_ready);
  modport slave  (input ev_code, input ev_valid, input ev_drop, output ev_ready);
endinterface

// File: rtl/key_code_encoder_debounce.sv
// key_debounce: two-flop synchroniser plus stability counter for one
// active-low key. pressed is the debounced level (1 = held); rose pulses
// for one cycle on the edge where pressed goes 0 -> 1.
module key_debounce
  import key_code_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pressed,
  output logic rose
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;
  logic             mismatch;

  // Bring the raw button into the clock domain; resets to released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= key_n;
      sync_q2 <= sync_q1;
    end
  end

  assign mismatch = (~sync_q2) != pressed;

  // Accept a level change only after it has been seen on DEBOUNCE_CYCLES consecutive cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pressed <= 1'b0;
      cnt     <= '0;
      rose    <= 1'b0;
    end else begin
      rose <= 1'b0;
      if (!mismatch) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        pressed <= ~pressed;
        cnt     <= '0;
        rose    <= ~pressed;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_code_encoder.sv
// key_code_encoder: debounces NUM_KEYS active-low buttons, reports the
// lowest-index held key as a level code and emits one handshaked event per
// debounced press. Optional auto-repeat of the held winner is enabled by
// defining KEY_REPEAT_EN.
module key_code_encoder
  import key_code_pkg::*;
#(
  parameter int NUM_KEYS        = DEF_NUM_KEYS,
  parameter int CODE_W          = DEF_CODE_W,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [CODE_W-1:0]   code,
  key_code_encoder_if.master  ev
);

  logic [NUM_KEYS-1:0] pressed;
  logic [NUM_KEYS-1:0] rose;
  logic [CODE_W-1:0]   key_table [NUM_KEYS];
  logic [CODE_W-1:0]   winner_code;
  logic [CODE_W-1:0]   press_code;
  logic                press_ev;
  logic                new_ev;
  logic [CODE_W-1:0]   new_code;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    localparam logic [MAX_CODE_W-1:0] ENTRY = key_code(i, CODE_W);
    assign key_table[i] = ENTRY[CODE_W-1:0];

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_n  (KEY[i]),
      .pressed(pressed[i]),
      .rose   (rose[i])
    );
  end

  // Lowest index wins, both for the held level and for newly pressed keys
  always_comb begin
    winner_code = '0;
    press_code  = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pressed[i]) winner_code = key_table[i];
      if (rose[i])    press_code  = key_table[i];
    end
  end

  assign press_ev = |rose;

  // Register the level code of the current winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) code <= '0;
    else        code <= winner_code;
  end

`ifdef KEY_REPEAT_EN
  logic [31:0] rpt_cnt;
  logic        rpt_armed;
  logic        rpt_restart;
  logic        rpt_fire;
  logic [31:0] rpt_limit;

  assign rpt_restart = press_ev || (winner_code != code);
  assign rpt_limit   = rpt_armed ? 32'(REPEAT_PERIOD - 1) : 32'(REPEAT_DELAY - 1);
  assign rpt_fire    = !rpt_restart && (code != '0) && (rpt_cnt == rpt_limit);

  // Time how long the winner has been held; first gap is REPEAT_DELAY, later ones REPEAT_PERIOD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else if (rpt_restart || (code == '0)) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b1;
    end else begin
      rpt_cnt <= rpt_cnt + 32'd1;
    end
  end

  assign new_ev   = press_ev || rpt_fire;
  assign new_code = press_ev ? press_code : code;
`else
  assign new_ev   = press_ev;
  assign new_code = press_code;
`endif

  ev_state_t         state_q;
  ev_state_t         state_d;
  logic [CODE_W-1:0] ev_code_q;
  logic [CODE_W-1:0] ev_code_d;
  logic              drop_q;
  logic              drop_d;

  // Event register: reload on accept without a bubble, drop new events while stalled
  always_comb begin
    state_d   = state_q;
    ev_code_d = ev_code_q;
    drop_d    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (new_ev) begin
          state_d   = FULL;
          ev_code_d = new_code;
        end
      end
      FULL: begin
        if (ev.ev_ready) begin
          if (new_ev) begin
            ev_code_d = new_code;
          end else begin
            state_d   = EMPTY;
            ev_code_d = '0;
          end
        end else if (new_ev) begin
          drop_d = 1'b1;
        end
      end
      default: begin
        state_d   = EMPTY;
        ev_code_d = '0;
      end
    endcase
  end

  // Event register state, code and drop pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      ev_code_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ev_code_q <= ev_code_d;
      drop_q    <= drop_d;
    end
  end

  assign ev.ev_valid = (state_q == FULL);
  assign ev.ev_code  = ev_code_q;
  assign ev.ev_drop  = drop_q;

endmodule

// File: tb/tb_key_code_encoder.sv
// tb_key_code_encoder: directed, table-driven bench for key_code_encoder
// with DEBOUNCE_CYCLES=4. Auto-repeat sequence runs when KEY_REPEAT_EN is defined.
module tb_key_code_encoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] KEY;
  logic [7:0] code;

  int tests;
  int failures;

  key_code_encoder_if #(.CODE_W(8)) ev_if ();

  key_code_encoder #(
    .NUM_KEYS       (4),
    .CODE_W         (8),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .KEY  (KEY),
    .code (code),
    .ev   (ev_if)
  );

  typedef struct {
    logic [3:0] key;
    logic       ready;
    int         cycles;
    logic [7:0] exp_code;
    logic       exp_valid;
    logic [7:0] exp_ev_code;
    logic       exp_drop;
  } vec_t;

  vec_t vecs[$];

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_output(input string tag, input logic [7:0] e_code, input logic e_valid,
                              input logic [7:0] e_ev_code, input logic e_drop);
    check({tag, " code"}, code, e_code);
    check({tag, " ev_valid"}, 8'(ev_if.ev_valid), 8'(e_valid));
    check({tag, " ev_code"}, ev_if.ev_code, e_ev_code);
    check({tag, " ev_drop"}, 8'(ev_if.ev_drop), 8'(e_drop));
  endtask

  task automatic apply_stimulus(input vec_t v);
    KEY             = v.key;
    ev_if.ev_ready  = v.ready;
    repeat (v.cycles) tick();
  endtask

  function automatic void add(input logic [3:0] key, input logic ready, input int cycles,
                              input logic [7:0] c, input logic v, input logic [7:0] ec,
                              input logic d);
    vecs.push_back('{key, ready, cycles, c, v, ec, d});
  endfunction

  initial begin
    tests          = 0;
    failures       = 0;
    rst_n          = 1'b0;
    KEY            = 4'b1111;
    ev_if.ev_ready = 1'b1;

    // Single key press and release, event consumed immediately
    add(4'b1111, 1, 2, 8'h00, 0, 8'h00, 0);
    add(4'b1011, 1, 6, 8'h00, 0, 8'h00, 0);
    add(4'b1011, 1, 1, 8'hA8, 1, 8'hA8, 0);
    add(4'b1011, 1, 1, 8'hA8, 0, 8'h00, 0);
    add(4'b1111, 1, 6, 8'hA8, 0, 8'h00, 0);
    add(4'b1111, 1, 1, 8'h00, 0, 8'h00, 0);
    // Bouncing key: 3-cycle glitches ignored, then one event once stable
    add(4'b1101, 1, 3, 8'h00, 0, 8'h00, 0);
    add(4'b1111, 1, 3, 8'h00, 0, 8'h00, 0);
    add(4'b1101, 1, 3, 8'h00, 0, 8'h00, 0);
    add(4'b1111, 1, 3, 8'h00, 0, 8'h00, 0);
    add(4'b1101, 1, 6, 8'h00, 0, 8'h00, 0);
    add(4'b1101, 1, 1, 8'hA0, 1, 8'hA0, 0);
    add(4'b1101, 1, 1, 8'hA0, 0, 8'h00, 0);
    add(4'b1111, 1, 7, 8'h00, 0, 8'h00, 0);
    // Higher-priority key pressed over a held key
    add(4'b0111, 1, 7, 8'hAA, 1, 8'hAA, 0);
    add(4'b0111, 1, 3, 8'hAA, 0, 8'h00, 0);
    add(4'b0110, 1, 6, 8'hAA, 0, 8'h00, 0);
    add(4'b0110, 1, 1, 8'h80, 1, 8'h80, 0);
    add(4'b0110, 1, 1, 8'h80, 0, 8'h00, 0);
    add(4'b0111, 1, 6, 8'h80, 0, 8'h00, 0);
    add(4'b0111, 1, 1, 8'hAA, 0, 8'h00, 0);
    add(4'b1111, 1, 7, 8'h00, 0, 8'h00, 0);
    // Stalled consumer: second press is dropped, then ready drains
    add(4'b1110, 0, 7, 8'h80, 1, 8'h80, 0);
    add(4'b1110, 0, 2, 8'h80, 1, 8'h80, 0);
    add(4'b1100, 0, 6, 8'h80, 1, 8'h80, 0);
    add(4'b1100, 0, 1, 8'h80, 1, 8'h80, 1);
    add(4'b1100, 0, 1, 8'h80, 1, 8'h80, 0);
    add(4'b1100, 1, 1, 8'h80, 0, 8'h00, 0);
    add(4'b1111, 1, 7, 8'h00, 0, 8'h00, 0);
    // Back-to-back presses one cycle apart: FULL->FULL reload
    add(4'b1110, 1, 1, 8'h00, 0, 8'h00, 0);
    add(4'b1100, 1, 5, 8'h00, 0, 8'h00, 0);
    add(4'b1100, 1, 1, 8'h80, 1, 8'h80, 0);
    add(4'b1100, 1, 1, 8'h80, 1, 8'hA0, 0);
    add(4'b1100, 1, 1, 8'h80, 0, 8'h00, 0);
    add(4'b1111, 1, 7, 8'h00, 0, 8'h00, 0);

    repeat (3) tick();
    check_output("reset", 8'h00, 0, 8'h00, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d", i), vecs[i].exp_code, vecs[i].exp_valid,
                   vecs[i].exp_ev_code, vecs[i].exp_drop);
    end

    // Reset asserted while an event is pending; held key must debounce again
    KEY            = 4'b1011;
    ev_if.ev_ready = 1'b0;
    repeat (7) tick();
    check_output("pre_reset", 8'hA8, 1, 8'hA8, 0);
    #2 rst_n = 1'b0;
    #1 check_output("mid_reset", 8'h00, 0, 8'h00, 0);
    repeat (2) tick();
    rst_n          = 1'b1;
    ev_if.ev_ready = 1'b1;
    repeat (6) tick();
    check_output("post_reset_wait", 8'h00, 0, 8'h00, 0);
    tick();
    check_output("post_reset_event", 8'hA8, 1, 8'hA8, 0);
    tick();
    check_output("post_reset_taken", 8'hA8, 0, 8'h00, 0);
    KEY = 4'b1111;
    repeat (8) tick();
    check_output("post_reset_release", 8'h00, 0, 8'h00, 0);

`ifdef KEY_REPEAT_EN
    // Held key: press event, first repeat 20 cycles later, then every 8
    KEY            = 4'b1110;
    ev_if.ev_ready = 1'b1;
    for (int t = 1; t <= 44; t++) begin
      logic exp_v;
      tick();
      exp_v = (t == 7) || (t == 27) || (t == 35) || (t == 43);
      check($sformatf("rpt_valid t%0d", t), 8'(ev_if.ev_valid), 8'(exp_v));
      if (exp_v) check($sformatf("rpt_code t%0d", t), ev_if.ev_code, 8'h80);
    end
    KEY = 4'b1111;
    repeat (8) tick();
    check_output("rpt_release", 8'h00, 0, 8'h00, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
